btb_update_buffer: RTL and testbench
====================================

Name: btb_update_buffer

Overview:
- Writer side of the BTB target-update port. Collects resolved taken-branch targets from the two commit slots and queues them in a small FIFO.
- Drains up to two entries per cycle onto the BTB write interface: pc_idx1/2, target_pc1/2, target_pc1_valid/2.
- Sits between the commit stage and the BTB. Applies backpressure to commit when full and holds writes while the BTB signals busy.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 4.
- PC_W, 64, PC and target width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- cm_br1_valid  in  1  commit slot 1 holds a resolved branch.
- cm_br1_taken  in  1  slot 1 branch was taken.
- cm_br1_pc  in  PC_W  slot 1 branch PC.
- cm_br1_target  in  PC_W  slot 1 resolved target.
- cm_br2_valid / cm_br2_taken / cm_br2_pc / cm_br2_target  in  1/1/PC_W/PC_W  same for slot 2 (slot 2 is younger).
- btb_busy  in  1  BTB cannot accept writes this cycle.
- upd_ready  out  1  buffer accepts two pushes this cycle.
- pc_idx1  out  PC_W  BTB write index, port 1 (oldest queued entry).
- target_pc1  out  PC_W  BTB write target, port 1.
- target_pc1_valid  out  1  port 1 write strobe.
- pc_idx2 / target_pc2 / target_pc2_valid  out  PC_W/PC_W/1  port 2 (second-oldest entry).
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (reset=0, async):
  - head, tail and occupancy cleared to 0.
  - All *_valid outputs 0; pc_idx*/target_pc* 0; upd_ready 1.
- Push condition: slot k pushes iff cm_brk_valid & cm_brk_taken & upd_ready. Not-taken or invalid slots are ignored.
- Push ordering:
  - Slot 1 enters before slot 2; 0, 1 or 2 pushes per cycle.
  - If both slots push with equal PC, only slot 2 is enqueued (younger target wins).
- upd_ready = (DEPTH − occupancy) ≥ 2, computed from registered occupancy only (no same-cycle pop credit).
- Pushes arriving while upd_ready=0 are a protocol violation. Commit must stall; the buffer drops them and never corrupts state.
- Write outputs:
  - Driven combinationally from the head entries (flopped storage).
  - target_pc1_valid = (occupancy ≥ 1) & ~btb_busy.
  - target_pc2_valid = (occupancy ≥ 2) & ~btb_busy.
- Pop: on a clock edge, the entries whose strobe was 1 are removed; 0, 1 or 2 pops per cycle.
- Latency: an entry pushed at edge N is visible on the outputs after edge N and can be written at edge N+1. No same-cycle bypass.
- Simultaneous push and pop are allowed; occupancy_next = occupancy + pushes − pops.
- Pointers wrap modulo DEPTH. Full = occupancy == DEPTH; empty = occupancy == 0.
- btb_busy=1: outputs hold their values with strobes 0, no pop; pushes still accepted while upd_ready=1.
- Reset mid-drain: queued entries are discarded without writing. The BTB stays consistent because BTB contents are only hints.

Optional Feature:
- Macro BTB_UPD_COALESCE_EN.
- Defined: each push compares its PC against all valid queued entries. On a match, the target is overwritten in place and no new entry is allocated; occupancy is unchanged for that push.
- Slot-2 compare also covers slot 1's same-cycle result.
- A match against an entry being popped that cycle allocates a new entry instead.
- Undefined: no CAM; duplicates are queued and written in order, so the later write wins at the BTB.

Decomposition:
- Shared package btb_pkg:
  - typedef btb_upd_t {pc, target}.
  - constants BTB_UPD_DEPTH=8 and BTB_PC_W=64.
- One natural sub-module, btb_upd_fifo: 2-push/2-pop circular buffer with occupancy. It does not contain push filtering, same-PC merge or coalescing.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → all valids 0, occupancy 0, upd_ready 1.
- Both slots taken, 0x92→0x10 and 0x96→0x2c, btb_busy=0 → next cycle pc_idx1=0x92/target_pc1=0x10 and pc_idx2=0x96/target_pc2=0x2c, both valid; occupancy 0 one cycle later.
- btb_busy=1 while pushing 4 taken branches (0x32→0x80, 0x36→0x64, 0x42→0x30, 0x46→0x50) → strobes 0, occupancy 4. Release busy → drains in order over 2 cycles.
- Fill to DEPTH−1 with busy=1 → upd_ready=0. A push attempted anyway is dropped, occupancy unchanged. One pop → upd_ready returns 1.
- Same-cycle duplicate: slot1 0x92→0x10, slot2 0x92→0x20 → one entry, target 0x20.
- Slot 1 not taken (0x42) with slot 2 taken (0x36→0x64) → only 0x36 is queued, and it appears on port 1. With BTB_UPD_COALESCE_EN, re-pushing 0x36→0x70 while queued → occupancy stays 1, target 0x70.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and default sizing for the BTB target-update path.
package btb_pkg;

  localparam int BTB_UPD_DEPTH = 8;
  localparam int BTB_PC_W      = 64;

  typedef struct packed {
    logic [BTB_PC_W-1:0] pc;
    logic [BTB_PC_W-1:0] target;
  } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular buffer with up to two pushes and two pops per cycle plus an entry count.
// With BTB_UPD_COALESCE_EN it also exposes storage and accepts in-place overwrites.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH,
  parameter int W     = 2 * BTB_PC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr0_en,
  input  logic [W-1:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [W-1:0]               wr1_data,
  input  logic [1:0]                 pop_cnt,
`ifdef BTB_UPD_COALESCE_EN
  input  logic                       ovr0_en,
  input  logic [$clog2(DEPTH)-1:0]   ovr0_idx,
  input  logic [W-1:0]               ovr0_data,
  input  logic                       ovr1_en,
  input  logic [$clog2(DEPTH)-1:0]   ovr1_idx,
  input  logic [W-1:0]               ovr1_data,
  output logic [DEPTH*W-1:0]         mem_flat,
  output logic [$clog2(DEPTH)-1:0]   head,
`endif
  output logic [W-1:0]               rd0_data,
  output logic [W-1:0]               rd1_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // A lone push always lands at the tail; the caller compacts its pushes onto wr0 first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr0_en) mem[tail_q]  <= wr0_data;
      if (wr1_en) mem[tail_p1] <= wr1_data;
`ifdef BTB_UPD_COALESCE_EN
      if (ovr0_en) mem[ovr0_idx] <= ovr0_data;
      if (ovr1_en) mem[ovr1_idx] <= ovr1_data;
`endif
      tail_q  <= tail_q + AW'(wr0_en) + AW'(wr1_en);
      head_q  <= head_q + AW'(pop_cnt);
      count_q <= count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop_cnt);
    end
  end

  assign rd0_data = mem[head_q];
  assign rd1_data = mem[head_p1];
  assign count    = count_q;

`ifdef BTB_UPD_COALESCE_EN
  assign head = head_q;
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*W +: W] = mem[g];
  end
`endif

endmodule

// File: rtl/btb_update_buffer.sv
// Queues taken-branch targets from two commit slots and drains them onto the BTB write ports.
// Optional BTB_UPD_COALESCE_EN merges pushes into queued entries with the same PC.
module btb_update_buffer
  import btb_pkg::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH,
  parameter int PC_W  = BTB_PC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cm_br1_valid,
  input  logic                     cm_br1_taken,
  input  logic [PC_W-1:0]          cm_br1_pc,
  input  logic [PC_W-1:0]          cm_br1_target,
  input  logic                     cm_br2_valid,
  input  logic                     cm_br2_taken,
  input  logic [PC_W-1:0]          cm_br2_pc,
  input  logic [PC_W-1:0]          cm_br2_target,
  input  logic                     btb_busy,
  output logic                     upd_ready,
  output logic [PC_W-1:0]          pc_idx1,
  output logic [PC_W-1:0]          target_pc1,
  output logic                     target_pc1_valid,
  output logic [PC_W-1:0]          pc_idx2,
  output logic [PC_W-1:0]          target_pc2,
  output logic                     target_pc2_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 2 * PC_W;

  logic         take1, take2, push1, push2;
  logic         alloc1, alloc2;
  logic [1:0]   pop_cnt;
  logic         wr0_en, wr1_en;
  logic [W-1:0] wr0_data, wr1_data, ent1, ent2;
  logic [W-1:0] rd0_data, rd1_data;

  // Ready only looks at registered occupancy, so this cycle's pops never count as credit.
  assign upd_ready        = (occupancy <= CW'(DEPTH - 2));
  assign target_pc1_valid = (occupancy != '0) & ~btb_busy;
  assign target_pc2_valid = (occupancy >= CW'(2)) & ~btb_busy;
  assign pop_cnt          = 2'(target_pc1_valid) + 2'(target_pc2_valid);

  assign take1 = cm_br1_valid & cm_br1_taken & upd_ready;
  assign take2 = cm_br2_valid & cm_br2_taken & upd_ready;
  // Same PC in both slots: the younger target supersedes, so slot 1 is dropped.
  assign push1 = take1 & ~(take2 & (cm_br1_pc == cm_br2_pc));
  assign push2 = take2;

  assign ent1 = {cm_br1_pc, cm_br1_target};
  assign ent2 = {cm_br2_pc, cm_br2_target};

`ifdef BTB_UPD_COALESCE_EN
  logic [DEPTH*W-1:0] mem_flat;
  logic [AW-1:0]      head;
  logic               hit1, hit2;
  logic [AW-1:0]      hit1_idx, hit2_idx;
  logic [AW-1:0]      off;
  logic               live;

  // Entries leaving this cycle are not merge candidates; a match there allocates anew.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit1_idx = '0;
    hit2_idx = '0;
    off      = '0;
    live     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off  = AW'(i) - head;
      live = (CW'(off) < occupancy) && (CW'(off) >= CW'(pop_cnt));
      if (live && !hit1 && (mem_flat[i*W+PC_W +: PC_W] == cm_br1_pc)) begin
        hit1     = 1'b1;
        hit1_idx = AW'(i);
      end
      if (live && !hit2 && (mem_flat[i*W+PC_W +: PC_W] == cm_br2_pc)) begin
        hit2     = 1'b1;
        hit2_idx = AW'(i);
      end
    end
  end

  assign alloc1 = push1 & ~hit1;
  assign alloc2 = push2 & ~hit2;
`else
  assign alloc1 = push1;
  assign alloc2 = push2;
`endif

  assign wr0_en   = alloc1 | alloc2;
  assign wr0_data = alloc1 ? ent1 : ent2;
  assign wr1_en   = alloc1 & alloc2;
  assign wr1_data = ent2;

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr0_en    (wr0_en),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_data  (wr1_data),
    .pop_cnt   (pop_cnt),
`ifdef BTB_UPD_COALESCE_EN
    .ovr0_en   (push1 & hit1),
    .ovr0_idx  (hit1_idx),
    .ovr0_data (ent1),
    .ovr1_en   (push2 & hit2),
    .ovr1_idx  (hit2_idx),
    .ovr1_data (ent2),
    .mem_flat  (mem_flat),
    .head      (head),
`endif
    .rd0_data  (rd0_data),
    .rd1_data  (rd1_data),
    .count     (occupancy)
  );

  assign pc_idx1    = rd0_data[W-1:PC_W];
  assign target_pc1 = rd0_data[PC_W-1:0];
  assign pc_idx2    = rd1_data[W-1:PC_W];
  assign target_pc2 = rd1_data[PC_W-1:0];

endmodule

// File: tb/tb_btb_update_buffer.sv
// Bench for btb_update_buffer: queue-based reference model plus directed literal checks.
module tb_btb_update_buffer;
  import btb_pkg::*;

  localparam int DEPTH = BTB_UPD_DEPTH;
  localparam int PC_W  = BTB_PC_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clock, reset;
  logic            cm_br1_valid, cm_br1_taken, cm_br2_valid, cm_br2_taken;
  logic [PC_W-1:0] cm_br1_pc, cm_br1_target, cm_br2_pc, cm_br2_target;
  logic            btb_busy, upd_ready;
  logic [PC_W-1:0] pc_idx1, target_pc1, pc_idx2, target_pc2;
  logic            target_pc1_valid, target_pc2_valid;
  logic [CW-1:0]   occupancy;

  btb_update_buffer dut (
    .clock(clock), .reset(reset),
    .cm_br1_valid(cm_br1_valid), .cm_br1_taken(cm_br1_taken),
    .cm_br1_pc(cm_br1_pc), .cm_br1_target(cm_br1_target),
    .cm_br2_valid(cm_br2_valid), .cm_br2_taken(cm_br2_taken),
    .cm_br2_pc(cm_br2_pc), .cm_br2_target(cm_br2_target),
    .btb_busy(btb_busy), .upd_ready(upd_ready),
    .pc_idx1(pc_idx1), .target_pc1(target_pc1), .target_pc1_valid(target_pc1_valid),
    .pc_idx2(pc_idx2), .target_pc2(target_pc2), .target_pc2_valid(target_pc2_valid),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  btb_upd_t model_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int n;
    n = model_q.size();
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("upd_ready", 64'(upd_ready), 64'((DEPTH - n) >= 2));
    chk("valid1", 64'(target_pc1_valid), 64'((n >= 1) && !btb_busy));
    chk("valid2", 64'(target_pc2_valid), 64'((n >= 2) && !btb_busy));
    if (n >= 1) begin
      chk("pc_idx1", pc_idx1, model_q[0].pc);
      chk("target_pc1", target_pc1, model_q[0].target);
    end
    if (n >= 2) begin
      chk("pc_idx2", pc_idx2, model_q[1].pc);
      chk("target_pc2", target_pc2, model_q[1].target);
    end
  endtask

  // Applies one clock edge to the model: strobed heads leave, accepted pushes join.
  task automatic model_update();
    int pops;
    bit ready, merged;
    btb_upd_t e;
    btb_upd_t pend[$];
    ready = (DEPTH - model_q.size()) >= 2;
    pops  = btb_busy ? 0 : ((model_q.size() < 2) ? model_q.size() : 2);
    repeat (pops) void'(model_q.pop_front());
    if (ready) begin
      if (cm_br1_valid && cm_br1_taken &&
          !(cm_br2_valid && cm_br2_taken && cm_br1_pc == cm_br2_pc)) begin
        e.pc = cm_br1_pc; e.target = cm_br1_target; pend.push_back(e);
      end
      if (cm_br2_valid && cm_br2_taken) begin
        e.pc = cm_br2_pc; e.target = cm_br2_target; pend.push_back(e);
      end
      foreach (pend[k]) begin
        merged = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
        foreach (model_q[j])
          if (!merged && model_q[j].pc == pend[k].pc) begin
            model_q[j].target = pend[k].target;
            merged = 1'b1;
          end
`endif
        if (!merged) model_q.push_back(pend[k]);
      end
    end
  endtask

  task automatic drive(input bit v1, input bit t1, input logic [63:0] p1, input logic [63:0] g1,
                       input bit v2, input bit t2, input logic [63:0] p2, input logic [63:0] g2,
                       input bit busy);
    cm_br1_valid = v1; cm_br1_taken = t1; cm_br1_pc = p1; cm_br1_target = g1;
    cm_br2_valid = v2; cm_br2_taken = t2; cm_br2_pc = p2; cm_br2_target = g2;
    btb_busy = busy;
  endtask

  task automatic idle(input bit busy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  task automatic cycle();
    #1 compare_model();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic drain();
    idle(0);
    for (int i = 0; i < DEPTH && model_q.size() > 0; i++) cycle();
    chk("drained", 64'(occupancy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle(0);
    repeat (2) @(negedge clock);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_valid1", 64'(target_pc1_valid), 64'd0);
    chk("rst_valid2", 64'(target_pc2_valid), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd1);
    chk("rst_pc_idx1", pc_idx1, 64'd0);
    chk("rst_target_pc2", target_pc2, 64'd0);
    reset = 1'b1;
    cycle();

    // Two pushes, visible next cycle, written the cycle after.
    drive(1, 1, 64'h92, 64'h10, 1, 1, 64'h96, 64'h2c, 0);
    cycle();
    idle(0);
    #1;
    chk("pair_pc1", pc_idx1, 64'h92);
    chk("pair_tg1", target_pc1, 64'h10);
    chk("pair_pc2", pc_idx2, 64'h96);
    chk("pair_tg2", target_pc2, 64'h2c);
    chk("pair_v1", 64'(target_pc1_valid), 64'd1);
    chk("pair_v2", 64'(target_pc2_valid), 64'd1);
    cycle();
    chk("pair_empty", 64'(occupancy), 64'd0);

    // Busy holds the queue; release drains in order.
    drive(1, 1, 64'h32, 64'h80, 1, 1, 64'h36, 64'h64, 1);
    cycle();
    drive(1, 1, 64'h42, 64'h30, 1, 1, 64'h46, 64'h50, 1);
    cycle();
    idle(1);
    #1;
    chk("busy_occ", 64'(occupancy), 64'd4);
    chk("busy_v1", 64'(target_pc1_valid), 64'd0);
    chk("busy_pc1", pc_idx1, 64'h32);
    idle(0);
    cycle();
    chk("busy_rel_pc1", pc_idx1, 64'h42);
    chk("busy_rel_tg1", target_pc1, 64'h30);
    chk("busy_rel_pc2", pc_idx2, 64'h46);
    cycle();
    chk("busy_rel_occ", 64'(occupancy), 64'd0);

    // Fill to DEPTH-1, then an illegal push must be dropped.
    drive(1, 1, 64'h200, 64'h1, 1, 1, 64'h204, 64'h2, 1); cycle();
    drive(1, 1, 64'h208, 64'h3, 1, 1, 64'h20c, 64'h4, 1); cycle();
    drive(1, 1, 64'h210, 64'h5, 1, 1, 64'h214, 64'h6, 1); cycle();
    drive(1, 1, 64'h218, 64'h7, 0, 0, 64'h0, 64'h0, 1);   cycle();
    chk("full_ready", 64'(upd_ready), 64'd0);
    drive(1, 1, 64'h500, 64'h9, 1, 1, 64'h504, 64'ha, 1); cycle();
    chk("full_drop_occ", 64'(occupancy), 64'd7);
    chk("full_drop_pc1", pc_idx1, 64'h200);
    idle(0);
    cycle();
    chk("full_pop_ready", 64'(upd_ready), 64'd1);
    chk("full_pop_pc1", pc_idx1, 64'h208);
    drain();

    // Same-cycle duplicate PC keeps only the younger target.
    drive(1, 1, 64'h92, 64'h10, 1, 1, 64'h92, 64'h20, 1);
    cycle();
    idle(1);
    #1;
    chk("dup_occ", 64'(occupancy), 64'd1);
    chk("dup_tg1", target_pc1, 64'h20);
    drain();

    // Not-taken slot 1 ignored; slot 2 lands on port 1.
    drive(1, 0, 64'h42, 64'h99, 1, 1, 64'h36, 64'h64, 1);
    cycle();
    idle(1);
    #1;
    chk("nt_occ", 64'(occupancy), 64'd1);
    chk("nt_pc1", pc_idx1, 64'h36);
    chk("nt_tg1", target_pc1, 64'h64);
    drive(1, 1, 64'h36, 64'h70, 0, 0, 64'h0, 64'h0, 1);
    cycle();
    idle(1);
    #1;
`ifdef BTB_UPD_COALESCE_EN
    chk("coal_occ", 64'(occupancy), 64'd1);
    chk("coal_tg1", target_pc1, 64'h70);
`else
    chk("repush_occ", 64'(occupancy), 64'd2);
    chk("repush_tg2", target_pc2, 64'h70);
`endif
    drain();

    // Reset while entries are queued discards them immediately.
    drive(1, 1, 64'h300, 64'h11, 1, 1, 64'h304, 64'h12, 1); cycle();
    drive(1, 1, 64'h308, 64'h13, 1, 1, 64'h30c, 64'h14, 1); cycle();
    idle(0);
    cycle();
    #2 reset = 1'b0;
    #1;
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_v1", 64'(target_pc1_valid), 64'd0);
    chk("midrst_pc1", pc_idx1, 64'd0);
    model_q.delete();
    @(negedge clock);
    reset = 1'b1;
    cycle();

    // Randomized traffic alternating light and heavy BTB busy periods.
    for (int i = 0; i < 1600; i++) begin
      bit busy;
      busy = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            64'h1000 + 64'($urandom_range(0, 7)) * 4, 64'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            64'h1000 + 64'($urandom_range(0, 7)) * 4, 64'($urandom), busy);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
